prog_sequencer: RTL and testbench

Instruction sequencer that drives the simple processor's `DIN`/`Run`/`Done` handshake from a small loadable program memory. Software or a testbench first writes a program into the internal memory, then pulses `Start`. The block issues one instruction at a time, waits for the processor to retire each one, advances the program counter, and stops after `Length` instructions or on `Stop`. It sits directly in front of the processor and replaces switch- or testbench-driven `DIN`/`Run`.

---
 rtl/prog_sequencer_if.sv | 9 +
 rtl/prog_sequencer.sv | 114 +++++++++++
 tb/tb_prog_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
// rtl/prog_sequencer_if.sv - instruction handshake between the sequencer and the processor
interface prog_sequencer_if;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;

  modport master (output DIN, output Run, input Done);
  modport slave  (input DIN, input Run, output Done);
endinterface

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - issues a loadable program one instruction at a time over DIN/Run/Done
module prog_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [15:0]       WrData,
  input  logic              Start,
  input  logic [ADDR_W:0]   Length,
  input  logic              Stop,
  output logic              Busy,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       Retired,
  output logic              Finished,
  output logic              Err,
  prog_sequencer_if.master  proc
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, state_nxt;

  logic [15:0]     mem [2**ADDR_W];
  logic [ADDR_W:0] remaining;
  logic [WW-1:0]   wait_cnt;
  logic            stop_pend;
  logic            start_ok;
  logic            start_zero;
  logic            timeout;
  logic            retire;
  logic            last;

  // Program memory is deliberately left out of reset.
  always_ff @(posedge Clock) begin
    if (WrEn && state == S_IDLE) mem[WrAddr] <= WrData;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    start_zero = 1'b0;
    timeout    = 1'b0;
    retire     = 1'b0;
    last       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (Length != '0) begin
            start_ok  = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        timeout = !proc.Done && (wait_cnt == WW'(MAX_WAIT));
        retire  = proc.Done || timeout;
        // A Stop arriving in the retire cycle itself still ends the run.
        last    = retire && (remaining == (ADDR_W+1)'(1) || stop_pend || Stop);
        if (retire) state_nxt = last ? S_IDLE : S_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      PC        <= '0;
      remaining <= '0;
      Retired   <= '0;
      Err       <= 1'b0;
      Finished  <= 1'b0;
      stop_pend <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      Finished <= start_zero || last;
      if (start_ok || start_zero) begin
        Retired <= '0;
        Err     <= 1'b0;
      end
      if (start_ok) begin
        PC        <= '0;
        remaining <= Length;
      end
      if (state == S_ISSUE)                wait_cnt <= WW'(1);
      else if (state == S_WAIT && !retire) wait_cnt <= wait_cnt + 1'b1;
      if (retire) begin
        Retired   <= Retired + 16'd1;
        remaining <= remaining - 1'b1;
        PC        <= PC + 1'b1;
        if (timeout) Err <= 1'b1;
      end
      if (state_nxt == S_IDLE)  stop_pend <= 1'b0;
      else if (Busy && Stop)    stop_pend <= 1'b1;
    end
  end

  assign Busy     = (state != S_IDLE);
  assign proc.Run = (state == S_ISSUE);
  assign proc.DIN = (state == S_ISSUE) ? mem[PC] : 16'h0000;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - directed and randomized bench for prog_sequencer with a processor stand-in
module tb_prog_sequencer;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          Clock   = 1'b0;
  logic          Resetn  = 1'b0;
  logic          WrEn    = 1'b0;
  logic [AW-1:0] WrAddr  = '0;
  logic [15:0]   WrData  = '0;
  logic          Start   = 1'b0;
  logic [AW:0]   Length  = '0;
  logic          Stop    = 1'b0;
  logic          Busy;
  logic [AW-1:0] PC;
  logic [15:0]   Retired;
  logic          Finished;
  logic          Err;

  int checks = 0;
  int errors = 0;

  prog_sequencer_if bus ();

  prog_sequencer #(.ADDR_W(AW), .MAX_WAIT(3)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .Start    (Start),
    .Length   (Length),
    .Stop     (Stop),
    .Busy     (Busy),
    .PC       (PC),
    .Retired  (Retired),
    .Finished (Finished),
    .Err      (Err),
    .proc     (bus.master)
  );

  always #5 Clock = ~Clock;

  // Processor stand-in: mv/mvt retire 1 cycle after issue, add/sub after 3, anything else never.
  logic        p_busy     = 1'b0;
  int          p_tick     = 0;
  logic [15:0] p_ir       = '0;
  logic [15:0] r [8];
  logic        extra_done = 1'b0;

  function automatic int lat_of(logic [15:0] w);
    if (w[15:13] <= 3'd1) return 1;
    if (w[15:13] <= 3'd3) return 3;
    return 0;
  endfunction

  function automatic logic [15:0] exec(logic [15:0] w, logic [15:0] rx, logic [15:0] ry);
    logic [15:0] opnd;
    opnd = w[12] ? {7'd0, w[8:0]} : ry;
    case (w[15:13])
      3'd0:    return opnd;
      3'd1:    return {w[7:0], 8'h00};
      3'd2:    return rx + opnd;
      default: return rx - opnd;
    endcase
  endfunction

  assign bus.Done = extra_done || (p_busy && p_tick == lat_of(p_ir));

  always @(posedge Clock) begin
    if (!Resetn) begin
      p_busy <= 1'b0;
      p_tick <= 0;
      for (int k = 0; k < 8; k++) r[k] <= '0;
    end else if (bus.Run) begin
      p_busy <= 1'b1;
      p_tick <= 1;
      p_ir   <= bus.DIN;
    end else if (p_busy) begin
      if (bus.Done) begin
        r[p_ir[11:9]] <= exec(p_ir, r[p_ir[11:9]], r[p_ir[2:0]]);
        p_busy <= 1'b0;
      end else if (p_tick >= 3) begin
        p_busy <= 1'b0;
      end else begin
        p_tick <= p_tick + 1;
      end
    end
  end

  // Expected timeline of one run, as offsets from the Start cycle.
  logic [15:0]   prog [DEPTH];
  bit            exp_run [512];
  logic [15:0]   exp_din [512];
  int            exp_fin;
  int            exp_ret;
  logic [AW-1:0] exp_pc = '0;
  logic          exp_err;

  task automatic model(input int len, input int stop_off);
    int t;
    int n;
    int lat;
    logic [15:0] w;
    t = 1;
    n = 0;
    exp_err = 1'b0;
    for (int k = 0; k < 512; k++) begin
      exp_run[k] = 1'b0;
      exp_din[k] = '0;
    end
    if (len == 0) begin
      exp_fin = 1;
      exp_ret = 0;
      return;
    end
    while (1) begin
      w   = prog[n % DEPTH];
      lat = (w[15:13] <= 3'd1) ? 2 : 4;
      if (w[15:13] > 3'd3) exp_err = 1'b1;
      exp_run[t] = 1'b1;
      exp_din[t] = w;
      n++;
      if (n == len || (stop_off >= 1 && stop_off <= t + lat - 1)) begin
        exp_fin = t + lat;
        break;
      end
      t += lat;
    end
    exp_ret = n;
    exp_pc  = AW'(n % DEPTH);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    @(posedge Clock); #1;
    WrEn   = 1'b1;
    WrAddr = AW'(a);
    WrData = d;
    prog[a] = d;
    @(posedge Clock); #1;
    WrEn = 1'b0;
  endtask

  task automatic run(input int len, input int stop_off, input int wr_off);
    model(len, stop_off);
    @(posedge Clock); #1;
    Start  = 1'b1;
    Length = (AW+1)'(len);
    for (int off = 1; off <= exp_fin + 1; off++) begin
      @(posedge Clock); #1;
      Start  = 1'b0;
      Stop   = (off == stop_off);
      WrEn   = (off == wr_off);
      WrAddr = '0;
      WrData = ~prog[0];
      @(negedge Clock);
      chk($sformatf("run@%0d", off), bus.Run, exp_run[off]);
      chk($sformatf("din@%0d", off), bus.DIN, exp_din[off]);
      chk($sformatf("busy@%0d", off), Busy, off < exp_fin);
      chk($sformatf("finished@%0d", off), Finished, off == exp_fin);
    end
    Stop = 1'b0;
    WrEn = 1'b0;
    chk("retired", Retired, exp_ret);
    chk("pc", PC, exp_pc);
    chk("err", Err, exp_err);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_run"}, bus.Run, 0);
    chk({tag, "_din"}, bus.DIN, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_pc"}, PC, 0);
    chk({tag, "_retired"}, Retired, 0);
    chk({tag, "_finished"}, Finished, 0);
    chk({tag, "_err"}, Err, 0);
  endtask

  initial begin
    logic [2:0] ops [5];
    int len;
    int stop_off;
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2; ops[3] = 3'd3; ops[4] = 3'd7;

    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;
    @(negedge Clock);
    chk_reset_values("reset");

    // mv then mvt
    write_word(0, 16'h1005);
    write_word(1, 16'h3212);
    run(2, 0, 0);
    chk("t1_r0", r[0], 16'h0005);
    chk("t1_r1", r[1], 16'h1200);

    // mv then add
    write_word(1, 16'h5003);
    run(2, 0, 0);
    chk("t2_r0", r[0], 16'h0008);

    // unused opcode times out
    write_word(0, 16'hE000);
    write_word(1, 16'h1001);
    run(2, 0, 0);
    chk("t3_r0", r[0], 16'h0001);

    // Stop during the first add
    write_word(0, 16'h5003);
    write_word(1, 16'h1005);
    write_word(2, 16'h1005);
    run(3, 2, 0);

    // write while busy is ignored, then re-run to observe mem[0]
    run(1, 0, 2);
    run(1, 0, 0);

    // Length=0 with a stray Done in IDLE
    extra_done = 1'b1;
    run(0, 0, 0);
    extra_done = 1'b0;

    // reset in the WAIT of an add that follows a timeout
    write_word(0, 16'hE000);
    write_word(1, 16'h5003);
    @(posedge Clock); #1;
    Start  = 1'b1;
    Length = (AW+1)'(2);
    for (int off = 1; off <= 6; off++) begin
      @(posedge Clock); #1;
      Start = 1'b0;
      if (off == 6) Resetn = 1'b0;
    end
    @(negedge Clock);
    chk("t6_err_before", Err, 1);
    @(posedge Clock); #1;
    Resetn = 1'b1;
    @(negedge Clock);
    chk_reset_values("t6");
    exp_pc = '0;
    run(2, 0, 0);
    chk("t6_r0", r[0], 16'h0003);

    // randomized programs, lengths past the memory depth, random Stop
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < DEPTH; a++)
        write_word(a, {ops[$urandom_range(0, 4)], 13'($urandom)});
      len = $urandom_range(1, 40);
      stop_off = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      run(len, stop_off, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
